// File: rtl/text_term_writer.sv
`default_nettype none
// ============================================================================
//  Module      : text_term_writer
//  Description : Character-terminal front end for a COLS x ROWS text display.
//                Consumes an ASCII byte stream, owns the cursor, and writes
//                characters into a 32-bit, 4-chars-per-word text buffer.
//                The buffer is addressed by byte = row*COLS+col: the word is
//                byte[11:2] and the lane is byte[1:0]. Control codes are
//                interpreted (LF, CR, BS, FF), and the buffer scrolls up by
//                one row when the cursor runs off the last row.
//  Options     : TERM_TAB_EN - when defined, 0x09 advances the cursor to the
//                next multiple of 8, wrapping like LF past the row end.
//  Ports       : CLOCK_50              system clock (rising edge)
//                clrn                  asynchronous active-low reset
//                char_valid/char_in    byte stream input
//                char_ready            byte accepted when valid && ready
//                busy                  clear or scroll in progress
//                mem_raddr/mem_rdata   synchronous read port (1-cycle latency)
//                mem_we/mem_waddr/mem_wdata/mem_be   byte-enabled write port
//                cur_row/cur_col       cursor position
//  Revision    : 1.0 - initial release
// ============================================================================
module text_term_writer #(
    parameter int          COLS  = 70,
    parameter int          ROWS  = 30,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic        CLOCK_50,
    input  logic        clrn,
    input  logic        char_valid,
    input  logic [7:0]  char_in,
    output logic        char_ready,
    output logic        busy,
    output logic [9:0]  mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic        mem_we,
    output logic [9:0]  mem_waddr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic [4:0]  cur_row,
    output logic [6:0]  cur_col
);

    localparam int c_CELLS     = COLS * ROWS;            // 2100 bytes on screen
    localparam int c_WORDS     = (c_CELLS + 3) / 4;      // 525 words to clear
    localparam int c_SCR_BYTES = COLS * (ROWS - 1);      // bytes moved by a scroll

    typedef enum logic [2:0] {
        S_INIT_CLR = 3'd0,
        S_IDLE     = 3'd1,
        S_PUT      = 3'd2,
        S_SCR_RD   = 3'd3,
        S_SCR_WR   = 3'd4,
        S_SCR_FILL = 3'd5,
        S_CLR      = 3'd6
    } state_t;

    state_t      state_q;
    logic [4:0]  row_q;
    logic [6:0]  col_q;
    logic [11:0] idx_q;       // clear word counter / scroll byte index
    logic        adv_q;       // PUT advances the cursor (printable) or not (BS)
    logic [1:0]  lane_q;      // source lane of the pending scroll read
    logic        ready_q;
    logic        busy_q;
    logic        we_q;
    logic [9:0]  waddr_q;
    logic [9:0]  raddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;

    logic        accept_d;
    logic        printable_d;
    logic        col_last_d;
    logic        row_last_d;
    logic        bs_moves_d;
    logic [4:0]  tgt_row_d;
    logic [6:0]  tgt_col_d;
    logic [11:0] tgt_addr_d;
    logic [11:0] idx_d;
    logic [11:0] src_d;
    logic        nl_d;
    logic [7:0]  rd_byte_d;
`ifdef TERM_TAB_EN
    logic [7:0]  tab_col_d;
`endif

    function automatic logic [3:0] f_onehot(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

    always_comb begin
        accept_d    = char_valid && ready_q;
        printable_d = (char_in >= 8'h20) && (char_in <= 8'h7E);
        col_last_d  = (col_q == 7'(COLS - 1));
        row_last_d  = (row_q == 5'(ROWS - 1));

        // Write target: the cursor itself, or the backed-up cell for BS.
        tgt_row_d  = row_q;
        tgt_col_d  = col_q;
        bs_moves_d = 1'b0;
        if (char_in == 8'h08) begin
            if (col_q != 7'd0) begin
                tgt_col_d  = col_q - 7'd1;
                bs_moves_d = 1'b1;
            end else if (row_q != 5'd0) begin
                tgt_row_d  = row_q - 5'd1;
                tgt_col_d  = 7'(COLS - 1);
                bs_moves_d = 1'b1;
            end
        end
        tgt_addr_d = 12'(tgt_row_d) * 12'(COLS) + 12'(tgt_col_d);

        idx_d = idx_q + 12'd1;
        // Source byte for the *next* scroll index, one row below it.
        src_d = idx_q + 12'(COLS) + 12'd1;

`ifdef TERM_TAB_EN
        tab_col_d = {1'b0, col_q[6:3] + 4'd1, 3'b000};
`endif

        // A new line is needed: LF, a tab past the row end, or a printable
        // written into the last column.
        nl_d = 1'b0;
        if (state_q == S_IDLE && accept_d && char_in == 8'h0A)
            nl_d = 1'b1;
`ifdef TERM_TAB_EN
        if (state_q == S_IDLE && accept_d && char_in == 8'h09 && tab_col_d >= 8'(COLS))
            nl_d = 1'b1;
`endif
        if (state_q == S_PUT && adv_q && col_last_d)
            nl_d = 1'b1;

        rd_byte_d = mem_rdata[8*lane_q +: 8];
    end

    always_ff @(posedge CLOCK_50 or negedge clrn) begin
        if (!clrn) begin
            state_q <= S_INIT_CLR;
            row_q   <= 5'd0;
            col_q   <= 7'd0;
            idx_q   <= 12'd0;
            adv_q   <= 1'b0;
            lane_q  <= 2'd0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            we_q    <= 1'b0;
            waddr_q <= 10'd0;
            raddr_q <= 10'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
        end else begin
            case (state_q)
                S_INIT_CLR, S_CLR: begin
                    // One blank word per cycle; the idx==c_WORDS cycle ends it.
                    if (idx_q == 12'(c_WORDS)) begin
                        state_q <= S_IDLE;
                        we_q    <= 1'b0;
                        be_q    <= 4'd0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        row_q   <= 5'd0;
                        col_q   <= 7'd0;
                    end else begin
                        we_q    <= 1'b1;
                        waddr_q <= idx_q[9:0];
                        be_q    <= 4'hF;
                        wdata_q <= {4{BLANK}};
                        idx_q   <= idx_d;
                    end
                end

                S_IDLE: begin
                    if (accept_d) begin
                        if (printable_d) begin
                            state_q <= S_PUT;
                            ready_q <= 1'b0;
                            adv_q   <= 1'b1;
                            we_q    <= 1'b1;
                            waddr_q <= tgt_addr_d[11:2];
                            be_q    <= f_onehot(tgt_addr_d[1:0]);
                            wdata_q <= {4{char_in}};
                        end else begin
                            case (char_in)
                                8'h08: begin
                                    if (bs_moves_d) begin
                                        row_q   <= tgt_row_d;
                                        col_q   <= tgt_col_d;
                                        state_q <= S_PUT;
                                        ready_q <= 1'b0;
                                        adv_q   <= 1'b0;
                                        we_q    <= 1'b1;
                                        waddr_q <= tgt_addr_d[11:2];
                                        be_q    <= f_onehot(tgt_addr_d[1:0]);
                                        wdata_q <= {4{BLANK}};
                                    end
                                end
                                8'h0D: col_q <= 7'd0;
                                8'h0C: begin
                                    state_q <= S_CLR;
                                    ready_q <= 1'b0;
                                    busy_q  <= 1'b1;
                                    idx_q   <= 12'd0;
                                end
`ifdef TERM_TAB_EN
                                8'h09: begin
                                    if (tab_col_d < 8'(COLS))
                                        col_q <= tab_col_d[6:0];
                                end
`endif
                                default: ;
                            endcase
                        end
                    end
                end

                S_PUT: begin
                    we_q    <= 1'b0;
                    be_q    <= 4'd0;
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    if (adv_q && !col_last_d)
                        col_q <= col_q + 7'd1;
                end

                S_SCR_RD: begin
                    // Read was issued on entry; data arrives during SCR_WR.
                    state_q <= S_SCR_WR;
                    we_q    <= 1'b1;
                    waddr_q <= idx_q[11:2];
                    be_q    <= f_onehot(idx_q[1:0]);
                end

                S_SCR_WR: begin
                    if (idx_q == 12'(c_SCR_BYTES - 1)) begin
                        state_q <= S_SCR_FILL;
                        idx_q   <= idx_d;
                        we_q    <= 1'b1;
                        waddr_q <= idx_d[11:2];
                        be_q    <= f_onehot(idx_d[1:0]);
                        wdata_q <= {4{BLANK}};
                    end else begin
                        state_q <= S_SCR_RD;
                        idx_q   <= idx_d;
                        we_q    <= 1'b0;
                        be_q    <= 4'd0;
                        raddr_q <= src_d[11:2];
                        lane_q  <= src_d[1:0];
                    end
                end

                S_SCR_FILL: begin
                    if (idx_q == 12'(c_CELLS - 1)) begin
                        state_q <= S_IDLE;
                        we_q    <= 1'b0;
                        be_q    <= 4'd0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        idx_q   <= idx_d;
                        waddr_q <= idx_d[11:2];
                        be_q    <= f_onehot(idx_d[1:0]);
                    end
                end

                default: state_q <= S_INIT_CLR;
            endcase

            // New-line handling overrides the state return chosen above.
            if (nl_d) begin
                col_q <= 7'd0;
                if (row_last_d) begin
                    state_q <= S_SCR_RD;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b1;
                    idx_q   <= 12'd0;
                    raddr_q <= 10'(COLS >> 2);
                    lane_q  <= 2'(COLS % 4);
                end else begin
                    row_q <= row_q + 5'd1;
                end
            end
        end
    end

    assign char_ready = ready_q;
    assign busy       = busy_q;
    assign mem_raddr  = raddr_q;
    assign mem_we     = we_q;
    assign mem_waddr  = waddr_q;
    assign mem_be     = be_q;
    // Scroll data comes straight from the RAM read port in the write cycle.
    assign mem_wdata  = (state_q == S_SCR_WR) ? {4{rd_byte_d}} : wdata_q;
    assign cur_row    = row_q;
    assign cur_col    = col_q;

endmodule
`default_nettype wire

// File: tb/tb_text_term_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_text_term_writer
//  Description : Self-checking bench for text_term_writer. Provides a
//                byte-enabled synchronous text RAM, a screen-level reference
//                model, a vector table, hand-written scroll/reset sequences
//                and a randomized character stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_text_term_writer;

    localparam int COLS  = 70;
    localparam int ROWS  = 30;
    localparam int CELLS = COLS * ROWS;

    logic        CLOCK_50;
    logic        clrn;
    logic        char_valid;
    logic [7:0]  char_in;
    logic        char_ready;
    logic        busy;
    logic [9:0]  mem_raddr;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic [9:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [4:0]  cur_row;
    logic [6:0]  cur_col;

    text_term_writer dut (
        .CLOCK_50  (CLOCK_50),
        .clrn      (clrn),
        .char_valid(char_valid),
        .char_in   (char_in),
        .char_ready(char_ready),
        .busy      (busy),
        .mem_raddr (mem_raddr),
        .mem_rdata (mem_rdata),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .cur_row   (cur_row),
        .cur_col   (cur_col)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    // ------------------------------------------------------------ text RAM
    logic [31:0] ram [0:1023];
    bit          ram_init_q = 1'b0;
    int          wr_cnt   = 0;
    int          inv_err  = 0;
    logic [9:0]  last_waddr;
    logic [3:0]  last_be;
    logic [31:0] last_wdata;

    always @(posedge CLOCK_50) begin
        mem_rdata <= ram[mem_raddr];
        if (!ram_init_q) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 32'hDEADBEEF;
            ram_init_q <= 1'b1;
        end else if (mem_we) begin
            for (int k = 0; k < 4; k++)
                if (mem_be[k]) ram[mem_waddr][8*k +: 8] <= mem_wdata[8*k +: 8];
            wr_cnt     <= wr_cnt + 1;
            last_waddr <= mem_waddr;
            last_be    <= mem_be;
            last_wdata <= mem_wdata;
            if (char_ready) inv_err <= inv_err + 1;
            if (!(mem_be inside {4'h1, 4'h2, 4'h4, 4'h8, 4'hF})) inv_err <= inv_err + 1;
        end
    end

    function automatic logic [7:0] ram_byte(input int b);
        logic [31:0] w;
        w = ram[b / 4];
        return w[8*(b % 4) +: 8];
    endfunction

    // ------------------------------------------------------------ checking
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------ model
    logic [7:0] m_scr [0:CELLS-1];
    int         m_row, m_col;

    task automatic m_clear();
        for (int b = 0; b < CELLS; b++) m_scr[b] = 8'h20;
        m_row = 0;
        m_col = 0;
    endtask

    task automatic m_newline();
        m_col = 0;
        if (m_row == ROWS - 1) begin
            for (int b = 0; b < CELLS - COLS; b++) m_scr[b] = m_scr[b + COLS];
            for (int b = CELLS - COLS; b < CELLS; b++) m_scr[b] = 8'h20;
        end else begin
            m_row++;
        end
    endtask

    task automatic m_apply(input logic [7:0] ch);
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            m_scr[m_row * COLS + m_col] = ch;
            if (m_col == COLS - 1) m_newline();
            else m_col++;
        end else if (ch == 8'h0A) begin
            m_newline();
        end else if (ch == 8'h0D) begin
            m_col = 0;
        end else if (ch == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                m_scr[m_row * COLS + m_col] = 8'h20;
            end else if (m_row > 0) begin
                m_row--;
                m_col = COLS - 1;
                m_scr[m_row * COLS + m_col] = 8'h20;
            end
        end else if (ch == 8'h0C) begin
            m_clear();
        end
`ifdef TERM_TAB_EN
        else if (ch == 8'h09) begin
            int t;
            t = (m_col / 8 + 1) * 8;
            if (t >= COLS) m_newline();
            else m_col = t;
        end
`endif
    endtask

    function automatic int buf_diffs();
        int n;
        n = 0;
        for (int b = 0; b < CELLS; b++)
            if (ram_byte(b) !== m_scr[b]) n++;
        return n;
    endfunction

    // ------------------------------------------------------------ driver
    int busy_cycles;

    task automatic wait_ready(input string name, input int limit);
        int n;
        n = 0;
        busy_cycles = 0;
        while (!char_ready && n < limit) begin
            if (busy) busy_cycles++;
            @(negedge CLOCK_50);
            n++;
        end
        if (!char_ready) begin
            errors++;
            $display("FAIL %s: timeout after %0d cycles waiting for char_ready", name, n);
        end
    endtask

    task automatic send(input logic [7:0] ch);
        wait_ready("send_pre", 10000);
        char_valid = 1'b1;
        char_in    = ch;
        @(negedge CLOCK_50);
        char_valid = 1'b0;
        m_apply(ch);
        wait_ready("send_post", 10000);
    endtask

    // ------------------------------------------------------------ vectors
    typedef struct {
        logic [7:0] ch;
        int         row;
        int         col;
        int         nwr;
        int         addr;
        logic [7:0] val;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        logic [7:0] ch;
        int r;

        tbl[0]  = '{8'h41, 0, 1,  1, 0,  8'h41};
        tbl[1]  = '{8'h42, 0, 2,  1, 1,  8'h42};
        tbl[2]  = '{8'h0D, 0, 0,  0, 0,  8'h00};
        tbl[3]  = '{8'h08, 0, 0,  0, 0,  8'h00};
        tbl[4]  = '{8'h0A, 1, 0,  0, 0,  8'h00};
        tbl[5]  = '{8'h08, 0, 69, 1, 69, 8'h20};
        tbl[6]  = '{8'h01, 0, 69, 0, 0,  8'h00};
        tbl[7]  = '{8'h5A, 1, 0,  1, 69, 8'h5A};
        tbl[8]  = '{8'h7E, 1, 1,  1, 70, 8'h7E};
        tbl[9]  = '{8'h7F, 1, 1,  0, 0,  8'h00};
        tbl[10] = '{8'h20, 1, 2,  1, 71, 8'h20};
        tbl[11] = '{8'h1B, 1, 2,  0, 0,  8'h00};

        clrn       = 1'b0;
        char_valid = 1'b0;
        char_in    = 8'h00;
        repeat (3) @(negedge CLOCK_50);

        // Reset state
        chk("rst_ready", char_ready, 0);
        chk("rst_busy", busy, 1);
        chk("rst_we", mem_we, 0);
        chk("rst_be", mem_be, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_cursor", {cur_row, cur_col}, 0);

        // Power-up clear
        w0 = wr_cnt;
        clrn = 1'b1;
        m_clear();
        wait_ready("init_clr", 2000);
        chk("init_writes", wr_cnt - w0, 525);
        chk("init_buffer", buf_diffs(), 0);
        chk("init_busy", busy, 0);
        chk("init_cursor", {cur_row, cur_col}, 0);

        // Table-driven single characters
        for (int k = 0; k < 12; k++) begin
            w0 = wr_cnt;
            send(tbl[k].ch);
            chk($sformatf("tbl%0d_row", k), cur_row, tbl[k].row);
            chk($sformatf("tbl%0d_col", k), cur_col, tbl[k].col);
            chk($sformatf("tbl%0d_nwr", k), wr_cnt - w0, tbl[k].nwr);
            if (tbl[k].nwr > 0) begin
                chk($sformatf("tbl%0d_waddr", k), last_waddr, tbl[k].addr / 4);
                chk($sformatf("tbl%0d_be", k), last_be, 4'b0001 << (tbl[k].addr % 4));
                chk($sformatf("tbl%0d_wdata", k), last_wdata, {4{tbl[k].val}});
            end
        end
        chk("tbl_buffer", buf_diffs(), 0);

        // Scroll sequence: 'Q' at byte 70, cursor to (29,5), then LF
        send(8'h0C);
        chk("ff_buffer", buf_diffs(), 0);
        chk("ff_cursor", {cur_row, cur_col}, 0);
        send(8'h0A);
        send(8'h51);
        for (int k = 0; k < 28; k++) send(8'h0A);
        send(8'h68); send(8'h65); send(8'h6C); send(8'h6C); send(8'h6F);
        chk("pre_scroll_cursor", {cur_row, cur_col}, {5'd29, 7'd5});
        send(8'h0A);
        chk("scroll_busy_cycles", busy_cycles, 4130);
        chk("scroll_byte0", ram_byte(0), 8'h51);
        chk("scroll_hello", {ram_byte(1960), ram_byte(1961), ram_byte(1962),
                             ram_byte(1963), ram_byte(1964)}, 40'h68656C6C6F);
        begin
            int nb;
            nb = 0;
            for (int b = 2030; b < 2100; b++) if (ram_byte(b) !== 8'h20) nb++;
            chk("scroll_last_row_blank", nb, 0);
        end
        chk("scroll_cursor", {cur_row, cur_col}, {5'd29, 7'd0});
        chk("scroll_buffer", buf_diffs(), 0);

        // Reset in the middle of a scroll
        wait_ready("mid_pre", 100);
        char_valid = 1'b1;
        char_in    = 8'h0A;
        @(negedge CLOCK_50);
        char_valid = 1'b0;
        repeat (2000) @(negedge CLOCK_50);
        chk("mid_busy", busy, 1);
        clrn = 1'b0;
        #1;
        chk("mid_rst_ready", char_ready, 0);
        chk("mid_rst_busy", busy, 1);
        chk("mid_rst_we", mem_we, 0);
        chk("mid_rst_be", mem_be, 0);
        chk("mid_rst_cursor", {cur_row, cur_col}, 0);
        repeat (3) @(negedge CLOCK_50);
        w0 = wr_cnt;
        clrn = 1'b1;
        m_clear();
        wait_ready("mid_clr", 2000);
        chk("mid_clr_writes", wr_cnt - w0, 525);
        chk("mid_clr_buffer", buf_diffs(), 0);
        chk("mid_clr_cursor", {cur_row, cur_col}, 0);

        // Random stream near the bottom so scrolls occur
        for (int k = 0; k < 27; k++) send(8'h0A);
        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 63);
            if (r < 2)       ch = 8'h0A;
            else if (r == 2) ch = 8'h0D;
            else if (r < 6)  ch = 8'h08;
            else if (r == 6) ch = 8'h09;
            else if (r == 7) ch = 8'h0C;
            else if (r < 10) begin
                case ($urandom_range(0, 5))
                    0: ch = 8'h00;
                    1: ch = 8'h07;
                    2: ch = 8'h1B;
                    3: ch = 8'h7F;
                    4: ch = 8'h80;
                    default: ch = 8'hFF;
                endcase
            end else ch = 8'($urandom_range(32, 126));
            send(ch);
            chk($sformatf("rnd%0d_cursor ch=%0h", k, ch), {cur_row, cur_col},
                {5'(m_row), 7'(m_col)});
            chk($sformatf("rnd%0d_buffer ch=%0h", k, ch), buf_diffs(), 0);
        end

        chk("invariants", inv_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
